// File: rtl/max_reduce_ctrl_if.sv
// Stream/handshake bundle for max_reduce_ctrl: job start, element input
// stream and held result output.
interface max_reduce_ctrl_if #(
  parameter int BITWIDTH = 16,
  parameter int MAX_LEN  = 64
) ();
  localparam int IDXW = $clog2(MAX_LEN);

  logic                start;
  logic [IDXW:0]       cfg_len;
  logic                busy;
  logic                cfg_err;
  logic                in_valid;
  logic                in_ready;
  logic [BITWIDTH-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [BITWIDTH-1:0] out_max;
  logic [IDXW-1:0]     out_idx;

  modport master (
    output start, cfg_len, in_valid, in_data, out_ready,
    input  busy, cfg_err, in_ready, out_valid, out_max, out_idx
  );

  modport slave (
    input  start, cfg_len, in_valid, in_data, out_ready,
    output busy, cfg_err, in_ready, out_valid, out_max, out_idx
  );
endinterface

// File: rtl/max_reduce_ctrl.sv
// Running-max reduction sequencer: folds a job of cfg_len streamed elements
// into a max and first-occurrence index, returned on a held output handshake.
module max_reduce_ctrl #(
  parameter int BITWIDTH = 16,
  parameter int MAX_LEN  = 64,
  parameter bit SIGNED   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  max_reduce_ctrl_if.slave bus
);
  localparam int IDXW = $clog2(MAX_LEN);
  localparam logic [IDXW:0] LEN_MAX = (IDXW + 1)'(MAX_LEN);
  localparam logic [IDXW:0] ONE     = (IDXW + 1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDXW:0]       len_q, len_d;
  logic [IDXW:0]       cnt_q, cnt_d;
  logic [BITWIDTH-1:0] max_q, max_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [BITWIDTH-1:0] out_max_q, out_max_d;
  logic [IDXW-1:0]     out_idx_q, out_idx_d;
  logic                cfg_err_q, cfg_err_d;

  logic                gt;
  logic                take;
  logic                cfg_ok;
  logic [BITWIDTH-1:0] new_max;
  logic [IDXW-1:0]     new_idx;

  generate
    if (SIGNED) begin : g_cmp_signed
      assign gt = $signed(bus.in_data) > $signed(max_q);
    end else begin : g_cmp_unsigned
      assign gt = bus.in_data > max_q;
    end
  endgenerate

  // Element 0 always seeds the running max; later elements need a strict win.
  assign take    = (cnt_q == '0) || gt;
  assign new_max = take ? bus.in_data : max_q;
  assign new_idx = take ? cnt_q[IDXW-1:0] : idx_q;
  assign cfg_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= LEN_MAX);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    idx_d     = idx_q;
    out_max_d = out_max_q;
    out_idx_d = out_idx_q;
    cfg_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cfg_ok) begin
            len_d   = bus.cfg_len;
            cnt_d   = '0;
            state_d = S_ACCUM;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_ACCUM: begin
        if (bus.in_valid) begin
          max_d = new_max;
          idx_d = new_idx;
          cnt_d = cnt_q + ONE;
          // Result registers only ever see the final fold, never a partial.
          if (cnt_q == len_q - ONE) begin
            out_max_d = new_max;
            out_idx_d = new_idx;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      max_q     <= '0;
      idx_q     <= '0;
      out_max_q <= '0;
      out_idx_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      max_q     <= max_d;
      idx_q     <= idx_d;
      out_max_q <= out_max_d;
      out_idx_q <= out_idx_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.in_ready  = (state_q == S_ACCUM);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_max   = out_max_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_max_reduce_ctrl.sv
// Scoreboard bench: a signed and an unsigned instance share one stimulus
// stream; expected results are queued per instance and checked by a monitor.
module tb_max_reduce_ctrl;
  logic clk;
  logic rst_n;

  max_reduce_ctrl_if #(.BITWIDTH(16), .MAX_LEN(64)) ifs ();
  max_reduce_ctrl_if #(.BITWIDTH(16), .MAX_LEN(64)) ifu ();

  max_reduce_ctrl #(.BITWIDTH(16), .MAX_LEN(64), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(ifs.slave)
  );
  max_reduce_ctrl #(.BITWIDTH(16), .MAX_LEN(64), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .bus(ifu.slave)
  );

  assign ifu.start     = ifs.start;
  assign ifu.cfg_len   = ifs.cfg_len;
  assign ifu.in_valid  = ifs.in_valid;
  assign ifu.in_data   = ifs.in_data;
  assign ifu.out_ready = ifs.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mx;
    logic [5:0]  ix;
  } exp_t;

  exp_t        qs[$];
  exp_t        qu[$];
  logic [15:0] vq[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: checks the head result every DONE cycle (stability), pops on handshake.
  always @(negedge clk) begin
    #2;
    if (ifs.out_valid) begin
      if (qs.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL s_unexpected_result actual=%0h required=none", ifs.out_max);
      end else begin
        chk("s_out_max", 32'(ifs.out_max), 32'(qs[0].mx));
        chk("s_out_idx", 32'(ifs.out_idx), 32'(qs[0].ix));
        chk("s_in_ready_in_done", 32'(ifs.in_ready), 32'd0);
        if (ifs.out_ready) begin
          $display("RESULT signed   max=%04h idx=%0d t=%0t", ifs.out_max, ifs.out_idx, $time);
          void'(qs.pop_front());
        end
      end
    end
    if (ifu.out_valid) begin
      if (qu.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u_unexpected_result actual=%0h required=none", ifu.out_max);
      end else begin
        chk("u_out_max", 32'(ifu.out_max), 32'(qu[0].mx));
        chk("u_out_idx", 32'(ifu.out_idx), 32'(qu[0].ix));
        if (ifu.out_ready) begin
          $display("RESULT unsigned max=%04h idx=%0d t=%0t", ifu.out_max, ifu.out_idx, $time);
          void'(qu.pop_front());
        end
      end
    end
  end

  // Runs one job from vq; duty is in_valid probability in percent, hold is
  // DONE cycles with out_ready low (0 = out_ready held high early).
  task automatic send_job(input logic [15:0] es_max, input int es_idx,
                          input logic [15:0] eu_max, input int eu_idx,
                          input int duty, input int hold, input bit poke);
    int len;
    int i;
    int guard;
    exp_t e;
    len   = vq.size();
    i     = 0;
    guard = 0;
    e.mx = es_max; e.ix = 6'(es_idx); qs.push_back(e);
    e.mx = eu_max; e.ix = 6'(eu_idx); qu.push_back(e);
    ifs.out_ready = (hold == 0);
    @(negedge clk);
    ifs.start   = 1'b1;
    ifs.cfg_len = 7'(len);
    @(negedge clk);
    ifs.start = 1'b0;
    chk("busy_after_start", 32'(ifs.busy), 32'd1);
    while (i < len && guard < 2000) begin
      if (duty >= 100 || $urandom_range(0, 99) < duty) begin
        ifs.in_valid = 1'b1;
        ifs.in_data  = vq[i];
      end else begin
        ifs.in_valid = 1'b0;
        ifs.in_data  = 16'hDEAD;
      end
      ifs.start   = poke;
      ifs.cfg_len = 7'd2;
      if (ifs.in_valid && ifs.in_ready) i++;
      guard++;
      @(negedge clk);
    end
    ifs.in_valid = 1'b0;
    ifs.in_data  = 16'h0BAD;
    ifs.start    = 1'b0;
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL element_timeout actual=%0d required=%0d", i, len);
    end
    chk("s_out_valid_latency", 32'(ifs.out_valid), 32'd1);
    chk("u_out_valid_latency", 32'(ifu.out_valid), 32'd1);
    chk("in_ready_done", 32'(ifs.in_ready), 32'd0);
    if (hold > 0) begin
      repeat (hold) begin
        @(negedge clk);
        chk("done_wait_valid", 32'(ifs.out_valid), 32'd1);
      end
      ifs.out_ready = 1'b1;
    end
    @(negedge clk);
    chk("out_valid_after_xfer", 32'(ifs.out_valid), 32'd0);
    chk("busy_after_xfer", 32'(ifs.busy), 32'd0);
    ifs.out_ready = 1'b0;
  endtask

  task automatic bad_start(input logic [6:0] len);
    @(negedge clk);
    ifs.start   = 1'b1;
    ifs.cfg_len = len;
    @(negedge clk);
    ifs.start = 1'b0;
    chk("cfg_err_pulse", 32'(ifs.cfg_err), 32'd1);
    chk("cfg_err_busy", 32'(ifs.busy), 32'd0);
    @(negedge clk);
    chk("cfg_err_clear", 32'(ifs.cfg_err), 32'd0);
    chk("cfg_err_busy2", 32'(ifs.busy), 32'd0);
    $display("CFG  len=%0d rejected t=%0t", len, $time);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"},      32'(ifs.busy),      32'd0);
    chk({tag, "_in_ready"},  32'(ifs.in_ready),  32'd0);
    chk({tag, "_out_valid"}, 32'(ifs.out_valid), 32'd0);
    chk({tag, "_cfg_err"},   32'(ifs.cfg_err),   32'd0);
    chk({tag, "_out_max"},   32'(ifs.out_max),   32'd0);
    chk({tag, "_out_idx"},   32'(ifs.out_idx),   32'd0);
    chk({tag, "_u_out_max"}, 32'(ifu.out_max),   32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    ifs.start     = 1'b0;
    ifs.cfg_len   = '0;
    ifs.in_valid  = 1'b0;
    ifs.in_data   = '0;
    ifs.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Mixed signs: signed max 12@2, unsigned max 0xFFF9(-7)@1
    vq = '{16'd3, 16'hFFF9, 16'd12, 16'd5};
    send_job(16'd12, 2, 16'hFFF9, 1, 100, 0, 1'b0);
    // Ties keep the first index; start poked during ACCUM must be ignored
    vq = '{16'd9, 16'd9, 16'd2, 16'd9, 16'd1};
    send_job(16'd9, 0, 16'd9, 0, 100, 0, 1'b1);
    vq = '{16'hFFFF, 16'h8000, 16'hFFFE};
    send_job(16'hFFFF, 0, 16'hFFFF, 0, 100, 0, 1'b0);
    vq = '{16'h0001, 16'h8000};
    send_job(16'h0001, 0, 16'h8000, 1, 100, 0, 1'b0);
    // All most-negative: that value is the max, first index
    vq = '{16'h8000, 16'h8000, 16'h8000};
    send_job(16'h8000, 0, 16'h8000, 0, 100, 0, 1'b0);
    // Stalled input (30% valid) and 5-cycle backpressure in DONE
    vq = '{16'hFFFB, 16'd100, 16'd100};
    send_job(16'd100, 1, 16'hFFFB, 0, 30, 5, 1'b0);
    // Full-length job: ascending 3*i, max at last index 63
    vq = {};
    for (int k = 0; k < 64; k++) vq.push_back(16'(3 * k));
    send_job(16'd189, 63, 16'd189, 63, 100, 0, 1'b0);

    bad_start(7'd0);
    bad_start(7'd65);

    // Abort mid-job with reset after 2 of 4 elements
    @(negedge clk);
    ifs.start   = 1'b1;
    ifs.cfg_len = 7'd4;
    @(negedge clk);
    ifs.start    = 1'b0;
    ifs.in_valid = 1'b1;
    ifs.in_data  = 16'd10;
    @(negedge clk);
    ifs.in_data = 16'd20;
    @(negedge clk);
    ifs.in_valid = 1'b0;
    chk("abort_busy_before_reset", 32'(ifs.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    $display("ABORT job reset after 2 elements t=%0t", $time);

    vq = '{16'd42};
    send_job(16'd42, 0, 16'd42, 0, 100, 0, 1'b0);

    repeat (3) @(negedge clk);
    chk("s_queue_drained", 32'(qs.size()), 32'd0);
    chk("u_queue_drained", 32'(qu.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
